// File: rtl/tx_msg_arbiter.sv
// tx_msg_arbiter: round-robin arbiter that shares the tx timestamp buffer's gPTP write port
// between NUM_REQ message sources and returns a done or err pulse to each winner.
module tx_msg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_vaild,
    input  logic [8*NUM_REQ-1:0]    req_addr,
    input  logic [80*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_err,
    output logic [7:0]              buf_wr_addr,
    output logic [79:0]             buf_wr_data,
    output logic                    buf_wr_vaild,
    input  logic                    buf_wr_ready,
    input  logic                    buf_wr_vaild_ready,
    output logic [2:0]              grant_id,
    output logic                    busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q;
    logic [2:0]         rr_ptr_q;
    logic [2:0]         grant_id_q;
    logic [7:0]         addr_q;
    logic [79:0]        data_q;
    logic               vld_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         sel_d;
    logic               ok_d;
    logic [3:0]         idx;
    logic [7:0]         vld_a;
    logic [7:0]         addr_a [8];
    logic [79:0]        data_a [8];

    // Pad requester lanes to 8 so a 3-bit grant index always selects in range.
    assign vld_a = 8'(req_vaild);
    for (genvar i = 0; i < 8; i++) begin : g_pad
        if (i < NUM_REQ) begin : g_on
            assign addr_a[i] = req_addr[8*i +: 8];
            assign data_a[i] = req_data[80*i +: 80];
        end else begin : g_off
            assign addr_a[i] = '0;
            assign data_a[i] = '0;
        end
    end

    function automatic logic [2:0] nxt(input logic [2:0] g);
        return (g == 3'(NUM_REQ - 1)) ? 3'd0 : g + 3'd1;
    endfunction

    // Walk offsets from far to near so the requester closest to rr_ptr wins.
    always_comb begin
        sel_d = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + 4'(k);
            idx = (idx >= 4'(NUM_REQ)) ? idx - 4'(NUM_REQ) : idx;
            sel_d = vld_a[idx[2:0]] ? idx[2:0] : sel_d;
        end
        ok_d = (addr_a[sel_d] != 8'd0) && ((addr_a[sel_d] & (addr_a[sel_d] - 8'd1)) == 8'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    // Skip the cycle an address error is visible so a held request is not rejected twice.
                    if (|req_vaild && buf_wr_vaild_ready && !(|err_q)) begin
                        grant_id_q <= sel_d;
                        addr_q     <= addr_a[sel_d];
                        data_q     <= data_a[sel_d];
                        if (ok_d) begin
                            state_q <= ISSUE;
                        end else begin
                            err_q    <= ONE << sel_d;
                            rr_ptr_q <= nxt(sel_d);
                        end
                    end
                end
                ISSUE: begin
                    vld_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (buf_wr_ready) begin
                        vld_q   <= 1'b0;
                        done_q  <= ONE << grant_id_q;
                        state_q <= DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        vld_q   <= 1'b0;
                        err_q   <= ONE << grant_id_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!buf_wr_ready) begin
                        rr_ptr_q <= nxt(grant_id_q);
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_done     = done_q;
    assign req_err      = err_q;
    assign buf_wr_addr  = addr_q;
    assign buf_wr_data  = data_q;
    assign buf_wr_vaild = vld_q;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_tx_msg_arbiter.sv
// tb_tx_msg_arbiter: scoreboard bench for tx_msg_arbiter with a behavioural buffer that
// raises ready after a programmable number of write-valid cycles.
module tb_tx_msg_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_vaild;
    logic [8*N-1:0] req_addr;
    logic [80*N-1:0] req_data;
    logic [N-1:0]   req_done, req_err;
    logic [7:0]     buf_wr_addr;
    logic [79:0]    buf_wr_data;
    logic           buf_wr_vaild, buf_wr_ready, buf_wr_vaild_ready;
    logic [2:0]     grant_id;
    logic           busy;

    typedef struct {
        logic [3:0]  done;
        logic [3:0]  err;
        logic [2:0]  gid;
        logic [7:0]  addr;
        logic [79:0] data;
    } exp_t;

    exp_t sb[$];
    int vectors = 0, errors = 0;
    int rdy_delay = 0, vcnt = 0, vcnt_last = 0, n_pulses = 0, vld_starts = 0;

    tx_msg_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req_vaild(req_vaild), .req_addr(req_addr), .req_data(req_data),
        .req_done(req_done), .req_err(req_err), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_wr_vaild(buf_wr_vaild), .buf_wr_ready(buf_wr_ready), .buf_wr_vaild_ready(buf_wr_vaild_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Buffer model and scoreboard consumer, sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        buf_wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (req_done != 0 || req_err != 0) begin
                n_pulses++;
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pulse: got done=%b err=%b gid=%0d, required no pulse", req_done, req_err, grant_id);
                end else begin
                    e = sb.pop_front();
                    if (req_done !== e.done || req_err !== e.err || grant_id !== e.gid) begin
                        errors++;
                        $display("FAIL pulse: got done=%b err=%b gid=%0d, required done=%b err=%b gid=%0d",
                                 req_done, req_err, grant_id, e.done, e.err, e.gid);
                    end
                end
            end
            if (buf_wr_vaild) begin
                vcnt++;
                if (vcnt == 1) begin
                    vld_starts++;
                    vectors++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL write: got addr=%h with nothing expected", buf_wr_addr);
                    end else if (buf_wr_addr !== sb[0].addr || buf_wr_data !== sb[0].data) begin
                        errors++;
                        $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                                 buf_wr_addr, buf_wr_data, sb[0].addr, sb[0].data);
                    end
                end
                if (rdy_delay > 0 && vcnt >= rdy_delay) buf_wr_ready = 1'b1;
            end else begin
                if (vcnt > 0) vcnt_last = vcnt;
                vcnt = 0;
                buf_wr_ready = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input logic [1:0] i, input logic [7:0] a, input logic [79:0] d);
        req_addr[{i, 3'b000} +: 8] = a;
        req_data[9'(i) * 9'd80 +: 80] = d;
        req_vaild[i] = 1'b1;
    endtask

    task automatic push(input logic [3:0] dn, input logic [3:0] er, input logic [2:0] g,
                        input logic [7:0] a, input logic [79:0] d);
        exp_t e;
        e.done = dn; e.err = er; e.gid = g; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    // Waits on falling edges until the pulse count reaches target; cyc = -1 if the budget expires.
    task automatic wait_pulses(input int target, input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (n_pulses >= target) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_vaild = '0;
        req_addr = '0;
        req_data = '0;
        buf_wr_vaild_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        vectors++; if (buf_wr_vaild !== 1'b0) begin errors++; $display("FAIL rst_vaild: got %b required 0", buf_wr_vaild); end
        vectors++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_gid: got %0d required 0", grant_id); end
        vectors++; if (buf_wr_addr !== 8'd0) begin errors++; $display("FAIL rst_addr: got %h required 0", buf_wr_addr); end
        vectors++; if (buf_wr_data !== 80'd0) begin errors++; $display("FAIL rst_data: got %h required 0", buf_wr_data); end
        vectors++; if ({req_done, req_err} !== 8'd0) begin errors++; $display("FAIL rst_pulse: got %b required 0", {req_done, req_err}); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_round_robin();
        int cyc;
        int order[5] = '{0, 1, 2, 3, 0};
        rdy_delay = 2;
        for (int k = 0; k < 5; k++)
            push(4'(1) << order[k], 4'd0, 3'(order[k]), 8'h01 << order[k], 80'hC0DE_0000 + 80'(order[k]));
        for (int i = 0; i < N; i++) set_req(2'(i), 8'h01 << i, 80'hC0DE_0000 + 80'(i));
        wait_pulses(n_pulses + 5, 120, cyc);
        req_vaild = '0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL rr_wait: got timeout required 5 pulses"); end
        repeat (4) @(negedge clk);
        vectors++; if (sb.size() != 0) begin errors++; $display("FAIL rr_left: got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_single();
        int cyc;
        rdy_delay = 5;
        push(4'b0001, 4'd0, 3'd0, 8'h04, 80'h0123456789ABCDEF0011);
        set_req(2'd0, 8'h04, 80'h0123456789ABCDEF0011);
        wait_pulses(n_pulses + 1, 40, cyc);
        req_vaild[0] = 1'b0;
        vectors++; if (cyc != 7) begin errors++; $display("FAIL single_latency: got %0d required 7", cyc); end
        vectors++; if (vcnt_last != 5) begin errors++; $display("FAIL single_vaild_cycles: got %0d required 5", vcnt_last); end
        vectors++; if (buf_wr_addr !== 8'h04) begin errors++; $display("FAIL single_addr_hold: got %h required 04", buf_wr_addr); end
        cyc = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin cyc = c; break; end
        end
        vectors++; if (cyc < 0) begin errors++; $display("FAIL single_idle: got busy=%b required 0", busy); end
    endtask

    task automatic test_bad_addr();
        int cyc;
        int vs = vld_starts;
        rdy_delay = 2;
        push(4'd0, 4'b0100, 3'd2, 8'h00, 80'd0);
        set_req(2'd2, 8'h00, 80'h1111);
        wait_pulses(n_pulses + 1, 10, cyc);
        req_vaild[2] = 1'b0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL bad_zero: got no err required err[2]"); end
        @(negedge clk);
        push(4'd0, 4'b0100, 3'd2, 8'h03, 80'd0);
        set_req(2'd2, 8'h03, 80'h2222);
        wait_pulses(n_pulses + 1, 10, cyc);
        req_vaild[2] = 1'b0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL bad_multi: got no err required err[2]"); end
        repeat (3) @(negedge clk);
        vectors++; if (vld_starts != vs) begin errors++; $display("FAIL bad_vaild: got %0d writes required 0", vld_starts - vs); end
    endtask

    task automatic test_timeout();
        int cyc;
        rdy_delay = 0;
        push(4'd0, 4'b0010, 3'd1, 8'h10, 80'hDEAD);
        set_req(2'd1, 8'h10, 80'hDEAD);
        wait_pulses(n_pulses + 1, 40, cyc);
        req_vaild[1] = 1'b0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL to_wait: got no pulse required err[1]"); end
        vectors++; if (vcnt_last != 15) begin errors++; $display("FAIL to_cycles: got %0d required 15", vcnt_last); end
        repeat (3) @(negedge clk);
        rdy_delay = 15;
        push(4'b1000, 4'd0, 3'd3, 8'h80, 80'hBEEF);
        set_req(2'd3, 8'h80, 80'hBEEF);
        wait_pulses(n_pulses + 1, 40, cyc);
        req_vaild[3] = 1'b0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL to_edge_wait: got no pulse required done[3]"); end
        vectors++; if (vcnt_last != 15) begin errors++; $display("FAIL to_edge_cycles: got %0d required 15", vcnt_last); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_not_idle();
        int cyc;
        int bad = 0;
        rdy_delay = 3;
        buf_wr_vaild_ready = 1'b0;
        set_req(2'd1, 8'h02, 80'h5A5A);
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin errors++; $display("FAIL ni_busy: got busy high %0d cycles required 0", bad); end
        vectors++; if (grant_id !== 3'd3) begin errors++; $display("FAIL ni_gid: got %0d required 3", grant_id); end
        push(4'b0010, 4'd0, 3'd1, 8'h02, 80'h5A5A);
        buf_wr_vaild_ready = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b1 || grant_id !== 3'd1) begin
            errors++; $display("FAIL ni_grant: got busy=%b gid=%0d required busy=1 gid=1", busy, grant_id);
        end
        wait_pulses(n_pulses + 1, 20, cyc);
        req_vaild[1] = 1'b0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL ni_wait: got no pulse required done[1]"); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int cyc;
        rdy_delay = 0;
        push(4'b0100, 4'd0, 3'd2, 8'h40, 80'h7777);
        set_req(2'd2, 8'h40, 80'h7777);
        cyc = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (buf_wr_vaild === 1'b1) begin cyc = c; break; end
        end
        vectors++; if (cyc < 0) begin errors++; $display("FAIL ar_issue: got vaild=%b required 1", buf_wr_vaild); end
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        req_vaild[2] = 1'b0;
        set_req(2'd1, 8'h02, 80'hAAAA);
        set_req(2'd3, 8'h08, 80'hBBBB);
        #1;
        vectors++; if ({busy, buf_wr_vaild, grant_id} !== 5'd0) begin
            errors++; $display("FAIL ar_ctrl: got busy=%b vaild=%b gid=%0d required 0", busy, buf_wr_vaild, grant_id);
        end
        vectors++; if (buf_wr_addr !== 8'd0 || buf_wr_data !== 80'd0) begin
            errors++; $display("FAIL ar_bus: got addr=%h data=%h required 0", buf_wr_addr, buf_wr_data);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rdy_delay = 2;
        push(4'b0010, 4'd0, 3'd1, 8'h02, 80'hAAAA);
        push(4'b1000, 4'd0, 3'd3, 8'h08, 80'hBBBB);
        reset = 1'b1;
        wait_pulses(n_pulses + 1, 20, cyc);
        req_vaild[1] = 1'b0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL ar_first: got no pulse required done[1]"); end
        wait_pulses(n_pulses + 1, 20, cyc);
        req_vaild[3] = 1'b0;
        vectors++; if (cyc < 0) begin errors++; $display("FAIL ar_second: got no pulse required done[3]"); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_bad_addr();
        test_timeout();
        test_not_idle();
        test_async_reset();
        vectors++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
